// File: rtl/register_file_param.sv
// Parameterised register file: one masked write port with same-cycle
// forwarding, two combinational read ports, and a handshaked full-array dump.
// All vectors are numbered [0:N-1] with bit 0 as the MSB; byte k is bits 8k..8k+7.
module register_file_param #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned ZERO_REG   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  we,
  input  logic [0:2]            sel,
  input  logic [0:DATA_WIDTH-1] data_in,
  input  logic [0:ADDR_WIDTH-1] addr_wr,
  input  logic [0:ADDR_WIDTH-1] addr_rd_0,
  input  logic [0:ADDR_WIDTH-1] addr_rd_1,
  output logic [0:DATA_WIDTH-1] data_out_0,
  output logic [0:DATA_WIDTH-1] data_out_1,
  input  logic                  dump_req,
  input  logic                  dump_ready,
  output logic                  dump_valid,
  output logic [0:ADDR_WIDTH-1] dump_addr,
  output logic [0:DATA_WIDTH-1] dump_data,
  output logic                  dump_busy,
  output logic                  dump_done
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;
  localparam int unsigned HALF  = DATA_WIDTH / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } state_t;

  logic [0:DATA_WIDTH-1] mem_q [DEPTH];
  logic [0:DATA_WIDTH-1] wr_mask;
  logic [0:DATA_WIDTH-1] entry_d;
  logic                  wr_en;

  state_t                state_q, state_d;
  logic [0:ADDR_WIDTH-1] ptr_q, ptr_d;

  // Write mask from the select code; codes above 100 select nothing.
  always_comb begin
    wr_mask = '0;
    for (int unsigned i = 0; i < DATA_WIDTH; i++) begin
      case (sel)
        3'b000:  wr_mask[i] = 1'b1;
        3'b001:  wr_mask[i] = (i < HALF);
        3'b010:  wr_mask[i] = (i >= HALF);
        3'b011:  wr_mask[i] = (((i / 8) % 2) == 0);
        3'b100:  wr_mask[i] = (((i / 8) % 2) == 1);
        default: wr_mask[i] = 1'b0;
      endcase
    end
  end

  // Merged write value; writes are blocked during reset and to a hardwired entry 0.
  always_comb begin
    wr_en   = we && reset && !((ZERO_REG != 0) && (addr_wr == '0));
    entry_d = (mem_q[addr_wr] & ~wr_mask) | (data_in & wr_mask);
  end

  // Storage array: async clear, masked write on the rising edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en) begin
      mem_q[addr_wr] <= entry_d;
    end
  end

  // Read ports with same-cycle forwarding of the merged write value.
  // Forwarding keys off wr_en, so a blocked write to entry 0 is never forwarded.
  always_comb begin
    data_out_0 = (wr_en && (addr_rd_0 == addr_wr)) ? entry_d : mem_q[addr_rd_0];
    data_out_1 = (wr_en && (addr_rd_1 == addr_wr)) ? entry_d : mem_q[addr_rd_1];
    if ((ZERO_REG != 0) && (addr_rd_0 == '0)) data_out_0 = '0;
    if ((ZERO_REG != 0) && (addr_rd_1 == '0)) data_out_1 = '0;
  end

  // Dump sequencer next-state: walk every entry, advancing on each accepted beat.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (dump_req) begin
          state_d = DUMP;
          ptr_d   = '0;
        end
      end
      DUMP: begin
        if (dump_ready) begin
          if (ptr_q == '1) begin
            state_d = DONE;
            ptr_d   = '0;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Dump sequencer state; reset aborts any dump in progress without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Dump outputs decoded from registered state; data is the stored (unforwarded) entry.
  always_comb begin
    dump_valid = (state_q == DUMP);
    dump_busy  = (state_q != IDLE);
    dump_done  = (state_q == DONE);
    dump_addr  = dump_valid ? ptr_q : '0;
    dump_data  = dump_valid ? mem_q[ptr_q] : '0;
    if ((ZERO_REG != 0) && (ptr_q == '0)) dump_data = '0;
  end

endmodule
